serial_word_feeder: RTL and testbench



---
 rtl/serial_word_feeder_pkg.sv | 15 +
 rtl/bit_period_timer.sv | 37 +++
 rtl/serial_word_feeder.sv | 125 ++++++++++++
 tb/tb_serial_word_feeder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder: FSM state encoding and counter sizing.
package serial_word_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Bits needed to count 0..term-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned term);
    return (term <= 32'd1) ? 32'd1 : 32'($clog2(term));
  endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Modulo-TERM cycle counter; tick marks the last enabled cycle of each period.
module bit_period_timer
  import serial_word_feeder_pkg::*;
#(
  parameter int unsigned TERM = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = cnt_width(TERM);
  localparam logic [CW-1:0] LAST = CW'(TERM - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: load/ready handshake, BIT_CYCLES-wide bit periods, optional idle gap.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP        = 0,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_next;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             x_out_q, x_out_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_tick, gap_tick;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  bit_period_timer #(.TERM(BIT_CYCLES)) u_bit_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_SHIFT),
    .enable (state_q == ST_SHIFT),
    .tick   (bit_tick)
  );

  bit_period_timer #(.TERM((GAP != 0) ? GAP : 1)) u_gap_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_GAP),
    .enable (state_q == ST_GAP),
    .tick   (gap_tick)
  );

  // x_out is loaded with the upcoming head bit on the same edge the shift register moves.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    x_out_d   = x_out_q;
    done_d    = 1'b0;
    sh_next   = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
    case (state_q)
      ST_IDLE: begin
        x_out_d = IDLE_LEVEL;
        if (load && ready_q) begin
          sh_d      = data_in;
          bit_cnt_d = '0;
          x_out_d   = head_bit(data_in);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            done_d    = 1'b1;
            x_out_d   = IDLE_LEVEL;
            bit_cnt_d = '0;
            state_d   = (GAP != 0) ? ST_GAP : ST_IDLE;
          end else begin
            sh_d      = sh_next;
            bit_cnt_d = bit_cnt_q + 1'b1;
            x_out_d   = head_bit(sh_next);
          end
        end
      end
      ST_GAP: begin
        x_out_d = IDLE_LEVEL;
        if (gap_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        x_out_d = IDLE_LEVEL;
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      x_out_q   <= IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      x_out_q   <= x_out_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready = ready_q;
  assign x_out = x_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder across three parameter sets sharing one clock.
module tb_serial_word_feeder;

  typedef struct packed {
    logic x;
    logic busy;
    logic done;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst_n  [3];
  logic       load_s [3];
  logic [7:0] din    [3];
  logic       x_s    [3];
  logic       rdy    [3];
  logic       busy_s [3];
  logic       done_s [3];

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  // 0: defaults, 1: LSB first with 2-cycle bits, 2: 3-cycle gap
  serial_word_feeder u_dut_a (
    .clock (clock), .reset (rst_n[0]), .data_in (din[0]), .load (load_s[0]),
    .ready (rdy[0]), .x_out (x_s[0]), .busy (busy_s[0]), .done (done_s[0])
  );

  serial_word_feeder #(.BIT_CYCLES(2), .MSB_FIRST(1'b0)) u_dut_b (
    .clock (clock), .reset (rst_n[1]), .data_in (din[1]), .load (load_s[1]),
    .ready (rdy[1]), .x_out (x_s[1]), .busy (busy_s[1]), .done (done_s[1])
  );

  serial_word_feeder #(.GAP(3)) u_dut_c (
    .clock (clock), .reset (rst_n[2]), .data_in (din[2]), .load (load_s[2]),
    .ready (rdy[2]), .x_out (x_s[2]), .busy (busy_s[2]), .done (done_s[2])
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs from the load edge up to and including the next IDLE cycle.
  task automatic push_word(input logic [7:0] d, input int unsigned bc, input bit msb,
                           input int unsigned gap);
    for (int unsigned k = 0; k < 8; k++) begin
      for (int unsigned c = 0; c < bc; c++) begin
        sb.push_back('{x: (msb ? d[7-k] : d[k]), busy: 1'b1, done: 1'b0});
      end
    end
    for (int unsigned g = 0; g < gap; g++) begin
      sb.push_back('{x: 1'b0, busy: 1'b1, done: (g == 0)});
    end
    sb.push_back('{x: 1'b0, busy: 1'b0, done: (gap == 0)});
  endtask

  task automatic step_check(input int idx, input string name);
    exp_t e;
    @(negedge clock);
    check_eq({name, "/sb_level"}, 8'(sb.size() != 0), 8'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({name, "/x_out"}, 8'(x_s[idx]), 8'(e.x));
      check_eq({name, "/busy"}, 8'(busy_s[idx]), 8'(e.busy));
      check_eq({name, "/done"}, 8'(done_s[idx]), 8'(e.done));
    end
  endtask

  task automatic idle_check(input int idx, input string name);
    check_eq({name, "/x_out"}, 8'(x_s[idx]), 8'd0);
    check_eq({name, "/ready"}, 8'(rdy[idx]), 8'd1);
    check_eq({name, "/busy"}, 8'(busy_s[idx]), 8'd0);
    check_eq({name, "/done"}, 8'(done_s[idx]), 8'd0);
  endtask

  task automatic run_word(input int idx, input string name, input logic [7:0] d,
                          input int unsigned bc, input bit msb, input int unsigned gap);
    @(negedge clock);
    din[idx]    = d;
    load_s[idx] = 1'b1;
    push_word(d, bc, msb, gap);
    step_check(idx, name);
    load_s[idx] = 1'b0;
    for (int unsigned t = 1; t < 8 * bc + gap + 1; t++) begin
      step_check(idx, name);
    end
    check_eq({name, "/ready_back"}, 8'(rdy[idx]), 8'd1);
    check_eq({name, "/sb_drain"}, 8'(sb.size()), 8'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < 3; i++) begin
      rst_n[i]  = 1'b0;
      load_s[i] = 1'b0;
      din[i]    = '0;
    end

    repeat (4) begin
      @(negedge clock);
      for (int unsigned i = 0; i < 3; i++) begin
        load_s[i] = ~load_s[i];
        din[i]    = 8'($urandom);
      end
      #1;
      for (int unsigned i = 0; i < 3; i++) idle_check(int'(i), "reset_hold");
    end
    @(negedge clock);
    for (int unsigned i = 0; i < 3; i++) begin
      load_s[i] = 1'b0;
      rst_n[i]  = 1'b1;
    end
    repeat (2) begin
      @(negedge clock);
      for (int unsigned i = 0; i < 3; i++) idle_check(int'(i), "reset_release");
    end

    run_word(0, "single_a5", 8'hA5, 1, 1'b1, 0);
    run_word(1, "lsb_0f_x2", 8'h0F, 2, 1'b0, 0);

    // Load held through both words; second word data only appears after the first accept.
    @(negedge clock);
    din[2]    = 8'hFF;
    load_s[2] = 1'b1;
    push_word(8'hFF, 1, 1'b1, 3);
    push_word(8'h00, 1, 1'b1, 3);
    for (int unsigned t = 0; t < 24; t++) begin
      step_check(2, "gap_b2b");
      if (t == 0) din[2] = 8'h00;
      if (t == 12) load_s[2] = 1'b0;
    end
    check_eq("gap_b2b/sb_drain", 8'(sb.size()), 8'd0);

    @(negedge clock);
    din[0]    = 8'hA5;
    load_s[0] = 1'b1;
    push_word(8'hA5, 1, 1'b1, 0);
    sb.push_back('{x: 1'b0, busy: 1'b0, done: 1'b0});
    sb.push_back('{x: 1'b0, busy: 1'b0, done: 1'b0});
    for (int unsigned t = 0; t < 11; t++) begin
      step_check(0, "load_busy");
      if (t == 0) load_s[0] = 1'b0;
      if (t == 3) begin
        din[0]    = 8'h3C;
        load_s[0] = 1'b1;
      end
      if (t == 4) load_s[0] = 1'b0;
    end
    check_eq("load_busy/sb_drain", 8'(sb.size()), 8'd0);

    @(negedge clock);
    din[0]    = 8'hA5;
    load_s[0] = 1'b1;
    push_word(8'hA5, 1, 1'b1, 0);
    for (int unsigned t = 0; t < 6; t++) begin
      step_check(0, "rst_mid");
      if (t == 0) load_s[0] = 1'b0;
    end
    check_eq("rst_mid/x_before", 8'(x_s[0]), 8'd1);
    #2 rst_n[0] = 1'b0;
    #1 idle_check(0, "rst_mid_async");
    sb.delete();
    @(negedge clock);
    idle_check(0, "rst_mid_hold");
    rst_n[0] = 1'b1;
    repeat (2) begin
      @(negedge clock);
      idle_check(0, "rst_mid_after");
    end
    run_word(0, "post_reset", 8'hA5, 1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
